// File: rtl/ocp_slave_ctrl.sv
// ocp_slave_ctrl: OCP single-request slave that bridges one command at a time
// onto a request/acknowledge backend (register file or memory).
// Adds an address-range decode, a backend timeout and byte enables.
// Optional feature macro: OCP_WRITE_RESP_EN.
//   defined   - every write returns DVA or ERR through the response handshake
//   undefined - writes are posted; no SResp for writes, only for reads and
//               reserved commands
// Handshakes:
//   command : accepted at a rising edge where SCmdAccept=1 and MCmd!=IDLE.
//   backend : be_req and be_* stay stable until be_ack=1 is sampled at an edge.
//   response: SResp/SData stay stable until MRespAccept=1 is sampled at an edge.
module ocp_slave_ctrl #(
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(16'h1000),
   parameter int                TIMEOUT    = 255,
   parameter int                TMO_W      = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          MCmd,
   input  logic [ADDR_W-1:0]   MAddr,
   input  logic [DATA_W-1:0]   MData,
   input  logic [DATA_W/8-1:0] MByteEn,
   input  logic                MRespAccept,
   output logic                SCmdAccept,
   output logic [1:0]          SResp,
   output logic [DATA_W-1:0]   SData,
   output logic                be_req,
   output logic                be_we,
   output logic [ADDR_W-1:0]   be_addr,
   output logic [DATA_W-1:0]   be_wdata,
   output logic [DATA_W/8-1:0] be_be,
   input  logic                be_ack,
   input  logic [DATA_W-1:0]   be_rdata,
   input  logic                be_err,
   output logic [1:0]          dbg_state
);

   localparam logic [2:0] CMD_IDLE = 3'b000;
   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;

   localparam logic [1:0] RESP_NULL = 2'b00;
   localparam logic [1:0] RESP_DVA  = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b11;

   // Counter value seen in the last REQ cycle before the timeout fires.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state;
   logic [TMO_W-1:0] tmo_cnt;

   assign dbg_state = state;

   // Main controller: command capture, backend request, response handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         SCmdAccept <= 1'b1;
         SResp      <= RESP_NULL;
         SData      <= '0;
         be_req     <= 1'b0;
         be_we      <= 1'b0;
         be_addr    <= '0;
         be_wdata   <= '0;
         be_be      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (MCmd != CMD_IDLE) begin
                  if (((MCmd == CMD_WR) || (MCmd == CMD_RD)) && (MAddr < ADDR_LIMIT)) begin
                     be_req     <= 1'b1;
                     be_we      <= (MCmd == CMD_WR);
                     be_addr    <= MAddr;
                     be_wdata   <= MData;
                     be_be      <= MByteEn;
                     tmo_cnt    <= '0;
                     SCmdAccept <= 1'b0;
                     state      <= ST_REQ;
                  end
`ifndef OCP_WRITE_RESP_EN
                  else if (MCmd == CMD_WR) begin
                     // Out-of-range posted write: dropped, keep accepting.
                     state <= ST_IDLE;
                  end
`endif
                  else begin
                     SResp      <= RESP_ERR;
                     SData      <= '0;
                     SCmdAccept <= 1'b0;
                     state      <= ST_RESP;
                  end
               end
            end

            ST_REQ: begin
               if (be_ack) begin
                  // An ack in the timeout cycle still completes normally.
                  be_req  <= 1'b0;
                  tmo_cnt <= '0;
                  if (be_we) begin
`ifdef OCP_WRITE_RESP_EN
                     SResp <= be_err ? RESP_ERR : RESP_DVA;
                     SData <= '0;
                     state <= ST_RESP;
`else
                     SCmdAccept <= 1'b1;
                     state      <= ST_IDLE;
`endif
                  end else begin
                     SResp <= be_err ? RESP_ERR : RESP_DVA;
                     SData <= be_err ? '0 : be_rdata;
                     state <= ST_RESP;
                  end
               end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                  be_req  <= 1'b0;
                  tmo_cnt <= '0;
`ifdef OCP_WRITE_RESP_EN
                  SResp <= RESP_ERR;
                  SData <= '0;
                  state <= ST_RESP;
`else
                  if (be_we) begin
                     SCmdAccept <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     SResp <= RESP_ERR;
                     SData <= '0;
                     state <= ST_RESP;
                  end
`endif
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               if (MRespAccept) begin
                  SResp      <= RESP_NULL;
                  SData      <= '0;
                  SCmdAccept <= 1'b1;
                  state      <= ST_IDLE;
               end
            end

            default: begin
               state      <= ST_IDLE;
               SCmdAccept <= 1'b1;
               SResp      <= RESP_NULL;
               SData      <= '0;
               be_req     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ocp_slave_ctrl.sv
// Bench for ocp_slave_ctrl: hand-filled vector table, randomized transactions
// scored by a transaction-level model, and reset / stray-ack sequences.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ocp_slave_ctrl;

  localparam int          TMO   = 4;
  localparam logic [15:0] LIMIT = 16'h1000;
  localparam logic [1:0]  R_NULL = 2'b00;
  localparam logic [1:0]  R_DVA  = 2'b01;
  localparam logic [1:0]  R_ERR  = 2'b11;
`ifdef OCP_WRITE_RESP_EN
  localparam bit WR_RESP = 1'b1;
`else
  localparam bit WR_RESP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  MCmd;
  logic [15:0] MAddr;
  logic [31:0] MData;
  logic [3:0]  MByteEn;
  logic        MRespAccept;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [31:0] SData;
  logic        be_req;
  logic        be_we;
  logic [15:0] be_addr;
  logic [31:0] be_wdata;
  logic [3:0]  be_be;
  logic        be_ack;
  logic [31:0] be_rdata;
  logic        be_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  cmd;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          ack_dly;   // REQ cycle (0-based) carrying be_ack; -1 = never
    logic [31:0] rdata;
    logic        err;
    int          acc_dly;   // cycles MRespAccept is held low
    bit          x_access;  // expected backend request
    int          x_req;     // expected number of cycles be_req is high
    logic [1:0]  x_resp;    // expected SResp (NULL = none)
    logic [31:0] x_sdata;
  } vec_t;

  vec_t tbl[11];

  ocp_slave_ctrl #(
    .ADDR_W(16), .DATA_W(32), .ADDR_LIMIT(LIMIT), .TIMEOUT(TMO), .TMO_W(8)
  ) dut (
    .clock(clock), .reset(reset), .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
    .MByteEn(MByteEn), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
    .SResp(SResp), .SData(SData), .be_req(be_req), .be_we(be_we),
    .be_addr(be_addr), .be_wdata(be_wdata), .be_be(be_be), .be_ack(be_ack),
    .be_rdata(be_rdata), .be_err(be_err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cmd, input logic [15:0] addr,
                              input logic [31:0] data, input logic [3:0] be,
                              input int ack_dly, input logic [31:0] rdata,
                              input logic err, input int acc_dly, input bit xa,
                              input int xr, input logic [1:0] xresp,
                              input logic [31:0] xsd);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.data = data; v.be = be;
    v.ack_dly = ack_dly; v.rdata = rdata; v.err = err; v.acc_dly = acc_dly;
    v.x_access = xa; v.x_req = xr; v.x_resp = xresp; v.x_sdata = xsd;
    return v;
  endfunction

  // Transaction-level reference: outcome of one command from its inputs alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit legal;
    bit is_wr;
    bit tmo;
    r = v;
    is_wr = (v.cmd == 3'd1);
    legal = ((v.cmd == 3'd1) || (v.cmd == 3'd2)) && (v.addr < LIMIT);
    tmo = legal && ((v.ack_dly < 0) || (v.ack_dly >= TMO));
    r.x_access = legal;
    r.x_req = !legal ? 0 : (tmo ? TMO : v.ack_dly + 1);
    r.x_sdata = '0;
    if (is_wr && !WR_RESP) r.x_resp = R_NULL;
    else if (!legal || tmo || v.err) r.x_resp = R_ERR;
    else begin
      r.x_resp = R_DVA;
      if (!is_wr) r.x_sdata = v.rdata;
    end
    return r;
  endfunction

  // driver: one full transaction, starting and ending just after a falling edge
  task automatic run_txn(input vec_t v, input string tag);
    chk({tag, "_cmdaccept_idle"}, SCmdAccept, 1'b1);
    MCmd = v.cmd; MAddr = v.addr; MData = v.data; MByteEn = v.be;
    @(posedge clock);
    @(negedge clock);
    MCmd = 3'd0; MAddr = 16'($urandom); MData = $urandom; MByteEn = 4'($urandom);
    if (v.x_access) begin
      for (int c = 0; c < v.x_req; c++) begin
        chk({tag, "_be_req"}, be_req, 1'b1);
        chk({tag, "_sresp_in_req"}, SResp, R_NULL);
        if (c == 0) begin
          chk({tag, "_be_we"}, be_we, (v.cmd == 3'd1));
          chk({tag, "_be_addr"}, be_addr, v.addr);
          chk({tag, "_be_wdata"}, be_wdata, v.data);
          chk({tag, "_be_be"}, be_be, v.be);
        end
        be_ack   = (c == v.ack_dly);
        be_rdata = be_ack ? v.rdata : $urandom;
        be_err   = be_ack ? v.err : 1'b0;
        @(posedge clock);
        @(negedge clock);
      end
      be_ack = 1'b0; be_err = 1'b0;
    end
    chk({tag, "_be_req_low"}, be_req, 1'b0);
    if (v.x_resp != R_NULL) begin
      chk({tag, "_sresp"}, SResp, v.x_resp);
      chk({tag, "_sdata"}, SData, v.x_sdata);
      chk({tag, "_cmdaccept_busy"}, SCmdAccept, 1'b0);
      for (int k = 0; k < v.acc_dly; k++) begin
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_sresp_hold"}, SResp, v.x_resp);
        chk({tag, "_sdata_hold"}, SData, v.x_sdata);
        chk({tag, "_cmdaccept_hold"}, SCmdAccept, 1'b0);
      end
      MRespAccept = 1'b1;
      @(posedge clock);
      @(negedge clock);
      MRespAccept = 1'b0;
    end
    chk({tag, "_sresp_done"}, SResp, R_NULL);
    chk({tag, "_sdata_done"}, SData, 32'h0);
    chk({tag, "_cmdaccept_done"}, SCmdAccept, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_be_req"}, be_req, 1'b0);
    chk({tag, "_sresp"}, SResp, R_NULL);
    chk({tag, "_cmdaccept"}, SCmdAccept, 1'b1);
  endtask

  initial begin
    vec_t v;
    // reset and idle inputs
    reset = 1'b1; MCmd = 3'd0; MAddr = '0; MData = '0; MByteEn = '0;
    MRespAccept = 1'b0; be_ack = 1'b0; be_rdata = '0; be_err = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_cmdaccept", SCmdAccept, 1'b1);
    chk("rst_sresp", SResp, R_NULL);
    chk("rst_sdata", SData, 32'h0);
    chk("rst_be_req", be_req, 1'b0);
    chk("rst_be_we", be_we, 1'b0);
    chk("rst_be_addr", be_addr, 16'h0);
    chk("rst_be_wdata", be_wdata, 32'h0);
    chk("rst_be_be", be_be, 4'h0);

    // vector table: cmd addr data be ack rdata err acc | access req resp sdata
    tbl[0]  = mk(3'd2, 16'h0010, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1, R_DVA, 32'hDEADBEEF);
    tbl[1]  = mk(3'd1, 16'h0004, 32'h12345678, 4'b0011, 0, 32'h0, 1'b0, 0, 1'b1, 1, WR_RESP ? R_DVA : R_NULL, 32'h0);
    tbl[2]  = mk(3'd2, 16'h1000, 32'h0, 4'hF, 0, 32'h11111111, 1'b0, 1, 1'b0, 0, R_ERR, 32'h0);
    tbl[3]  = mk(3'd2, 16'h0020, 32'h0, 4'hF, -1, 32'h0, 1'b0, 0, 1'b1, 4, R_ERR, 32'h0);
    tbl[4]  = mk(3'd2, 16'h0024, 32'h0, 4'hF, 3, 32'hCAFEF00D, 1'b0, 0, 1'b1, 4, R_DVA, 32'hCAFEF00D);
    tbl[5]  = mk(3'd2, 16'h0030, 32'h0, 4'hF, 1, 32'h55AA55AA, 1'b1, 5, 1'b1, 2, R_ERR, 32'h0);
    tbl[6]  = mk(3'd1, 16'h1000, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0, 0, WR_RESP ? R_ERR : R_NULL, 32'h0);
    tbl[7]  = mk(3'd5, 16'h0040, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1, 1'b0, 0, R_ERR, 32'h0);
    tbl[8]  = mk(3'd1, 16'h0FFC, 32'h00000001, 4'b1000, 2, 32'h0, 1'b1, 0, 1'b1, 3, WR_RESP ? R_ERR : R_NULL, 32'h0);
    tbl[9]  = mk(3'd1, 16'h0008, 32'h87654321, 4'hF, -1, 32'h0, 1'b0, 0, 1'b1, 4, WR_RESP ? R_ERR : R_NULL, 32'h0);
    tbl[10] = mk(3'd2, 16'h0FFF, 32'h0, 4'hF, 0, 32'h0BADF00D, 1'b0, 0, 1'b1, 1, R_DVA, 32'h0BADF00D);
    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // stray be_ack while idle must do nothing
    be_ack = 1'b1; be_err = 1'b1; be_rdata = 32'hFFFFFFFF;
    @(posedge clock);
    @(negedge clock);
    be_ack = 1'b0; be_err = 1'b0;
    check_idle("stray_ack");

    // reset while in REQ
    MCmd = 3'd2; MAddr = 16'h0100;
    @(posedge clock);
    @(negedge clock);
    MCmd = 3'd0;
    chk("rstreq_pre_be_req", be_req, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle("rstreq");
    run_txn(tbl[0], "after_rstreq");

    // reset while in RESP
    MCmd = 3'd2; MAddr = 16'h2000;
    @(posedge clock);
    @(negedge clock);
    MCmd = 3'd0;
    chk("rstresp_pre_sresp", SResp, R_ERR);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle("rstresp");
    chk("rstresp_sdata", SData, 32'h0);
    run_txn(tbl[4], "after_rstresp");

    // randomized transactions scored by the model
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      v.cmd = (sel < 5) ? 3'd2 : (sel < 9) ? 3'd1 : 3'($urandom_range(3, 7));
      v.addr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0FF8, 16'h1008))
                                           : 16'($urandom_range(0, 16'hFFFF));
      v.data = $urandom;
      v.be = 4'($urandom);
      v.ack_dly = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 5);
      v.rdata = $urandom;
      v.err = ($urandom_range(0, 4) == 0);
      v.acc_dly = $urandom_range(0, 3);
      run_txn(model(v), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ocp_slave_ctrl.md
Name: ocp_slave_ctrl

Overview:
- Parametrised successor to the basic OCP slave R/W controller.
- Accepts single-request OCP commands (IDLE/WR/RD) from a master and drives one backend request/acknowledge port (register file or memory).
- Returns OCP responses with an MRespAccept handshake.
- Adds address-range decode errors, a backend timeout, byte enables and one outstanding transaction at a time.

Parameters:
- ADDR_W, 16, width of MAddr / be_addr
- DATA_W, 32, width of data buses; must be a multiple of 8
- ADDR_LIMIT, 16'h1000, first illegal address; an address >= ADDR_LIMIT yields ERR with no backend access
- TIMEOUT, 255, max cycles to wait for be_ack; 0 disables the timeout
- TMO_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- MCmd  in  3  3'b000 IDLE, 3'b001 WR, 3'b010 RD, others reserved
- MAddr  in  ADDR_W  request address
- MData  in  DATA_W  write data
- MByteEn  in  DATA_W/8  byte enables
- MRespAccept  in  1  master accepts the current response
- SCmdAccept  out  1  slave accepts the command this cycle
- SResp  out  2  2'b00 NULL, 2'b01 DVA, 2'b11 ERR
- SData  out  DATA_W  read data, valid while SResp != NULL
- be_req  out  1  backend request
- be_we  out  1  1 = write
- be_addr  out  ADDR_W  backend address
- be_wdata  out  DATA_W  backend write data
- be_be  out  DATA_W/8  backend byte enables
- be_ack  in  1  backend done
- be_rdata  in  DATA_W  backend read data, valid with be_ack
- be_err  in  1  backend error, valid with be_ack

Behaviour:
- Clock and reset: one clock `clock`; `reset` is synchronous and active-high. All outputs are registered.
- Reset values: SCmdAccept=1, SResp=NULL, SData=0, be_req=0, be_we=0, be_addr=0, be_wdata=0, be_be=0, state=IDLE, timeout counter=0.
- States: IDLE, REQ, RESP.
- IDLE:
  - SCmdAccept=1. A command is accepted when MCmd!=IDLE at a rising edge.
  - MAddr, MData, MByteEn and the command type are captured and SCmdAccept goes to 0 at the next edge.
  - Legal RD/WR with MAddr < ADDR_LIMIT -> REQ: be_req=1 and be_* are driven from the captured values.
  - Out-of-range address, or reserved MCmd -> RESP with ERR, SData=0, no be_req.
- REQ:
  - be_req is held and be_* are stable until be_ack=1 is sampled. be_ack is legal in the first REQ cycle.
  - On ack, be_req=0 at the next edge.
  - Read: SData<=be_rdata, SResp<=DVA, or ERR if be_err (SData=0 on ERR) -> RESP.
  - Write: go to RESP, or straight to IDLE; see Optional Feature.
  - Timeout counter clears on entering REQ and increments each REQ cycle without ack. When it reaches TIMEOUT (TIMEOUT!=0): be_req=0, SResp=ERR, SData=0 -> RESP. A be_ack that arrives in the same cycle as the timeout wins.
- RESP:
  - SResp and SData are held until MRespAccept=1 is sampled.
  - At that edge: SResp=NULL, SData=0, SCmdAccept=1 -> IDLE.
- Minimum latencies:
  - Read with immediate ack: command accept edge -> be_req -> ack edge -> SResp valid, i.e. SResp is valid 2 cycles after the accept edge.
  - Next command can be accepted 1 cycle after MRespAccept.
- Outstanding transactions: exactly one. MCmd is ignored while SCmdAccept=0; the master holds its command per OCP rules.
- be_ack outside REQ is ignored.
- Reset in any state takes effect at the next edge: be_req drops, any pending response is discarded with no SResp, and the block returns to IDLE.

Optional Feature:
- Macro: OCP_WRITE_RESP_EN.
- With the macro defined: every write produces a response. Normal completion gives DVA; be_err, out-of-range address or timeout gives ERR. The response follows the RESP handshake above.
- Without the macro: writes are posted.
  - Backend ack returns the block to IDLE directly, with SCmdAccept=1 at the next edge and no SResp.
  - Out-of-range writes are dropped silently; no REQ, return to IDLE.
  - Write timeout returns to IDLE silently.
  - Reserved commands still return ERR.

Test Plan:
- Reset, then MCmd=RD, MAddr=0x0010; backend acks in the first REQ cycle with be_rdata=0xDEADBEEF -> SResp=DVA and SData=0xDEADBEEF 2 cycles after accept; held until MRespAccept; SCmdAccept=1 the cycle after.
- MCmd=WR, MAddr=0x0004, MData=0x12345678, MByteEn=4'b0011 -> be_we=1, be_wdata=0x12345678, be_be=0011. With macro: SResp=DVA. Without: no SResp, return to IDLE after ack.
- MCmd=RD, MAddr=0x1000 (=ADDR_LIMIT) -> be_req never asserted; SResp=ERR, SData=0 the cycle after accept.
- RD with be_ack held low, TIMEOUT=4 -> be_req drops after 4 REQ cycles; SResp=ERR. Repeat with be_ack arriving in the 4th cycle -> DVA.
- RD acked with be_err=1 -> SResp=ERR. MRespAccept held low for 5 cycles -> SResp stays ERR, SCmdAccept stays 0.
- Assert reset while in REQ and while in RESP -> next edge: be_req=0, SResp=NULL, SCmdAccept=1; a new RD is then serviced normally.
